// File: rtl/sbox_share_pkg.sv
// sbox_share_pkg: shared types and constants for the sbox lane sequencer
//   state_t  : sequencer FSM states
//   ST_BYTES : bytes in a cipher-state job, KW_BYTES : bytes in a key-word job
//   REQ_ST/REQ_KW : requester ids used by the round-robin pointer
package sbox_share_pkg;
    typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_t;
    localparam int ST_BYTES = 16;
    localparam int KW_BYTES = 4;
    localparam logic REQ_ST = 1'b0;
    localparam logic REQ_KW = 1'b1;
endpackage

// File: rtl/sbox.sv
// sbox: combinational AES forward S-box, GF(2^8) inverse followed by the affine map
//   a : input byte
//   y : S-box output byte
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] r;
        logic [7:0] s;
        r = '0;
        s = p;
        for (int i = 0; i < 8; i++) begin
            r = q[i] ? r ^ s : r;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] sq(input logic [7:0] v);
        return gmul(v, v);
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, inv;

    // inverse as a^254 through an addition chain; a=0 naturally maps to 0
    always_comb begin
        x2   = sq(a);
        x3   = gmul(x2, a);
        x12  = sq(sq(x3));
        x15  = gmul(x12, x3);
        x240 = sq(sq(sq(sq(x15))));
        inv  = gmul(gmul(x240, x12), x2);
        y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: shares NUM_SBOX sbox lanes between SubBytes (ST) and SubWord (KW) jobs
//   clk, rst                 : clock, asynchronous active-high reset
//   st_req/st_in             : ST request and 128-bit state (byte 0 in the MSBs)
//   st_gnt/st_done/st_out    : ST accept pulse, result-valid pulse, registered SubBytes result
//   kw_req/kw_in             : KW request and 32-bit key word
//   kw_gnt/kw_done/kw_out    : KW accept pulse, result-valid pulse, registered SubWord result
//   busy                     : a job is being streamed through the lanes
module sbox_share_ctrl import sbox_share_pkg::*; #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_gnt,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_gnt,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);
    localparam int LG = $clog2(NUM_SBOX);
    localparam logic [3:0] ST_LAST = 4'(ST_BYTES / NUM_SBOX - 1);
    localparam logic [3:0] KW_LAST = 4'((KW_BYTES + NUM_SBOX - 1) / NUM_SBOX - 1);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad
        $error("sbox_share_ctrl: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    state_t state, state_nxt;
    logic [3:0] chunk, base;
    logic prio, last;
    logic [0:15][7:0] job, res, res_nxt;
    logic [7:0] lane_in [NUM_SBOX];
    logic [7:0] lane_out [NUM_SBOX];

    assign busy = (state != IDLE);

    always_comb begin
        st_gnt    = (state == IDLE) && st_req && (!kw_req || prio == REQ_ST);
        kw_gnt    = (state == IDLE) && kw_req && (!st_req || prio == REQ_KW);
        last      = (chunk == ((state == ST_RUN) ? ST_LAST : KW_LAST));
        state_nxt = (state == IDLE) ? (st_gnt ? ST_RUN : kw_gnt ? KW_RUN : IDLE) : (last ? IDLE : state);
    end

    // chunk*NUM_SBOX is a multiple of the lane count, so OR-ing the lane index adds it
    always_comb begin
        base = chunk << LG;
        for (int k = 0; k < NUM_SBOX; k++)
            lane_in[k] = (state == IDLE) ? 8'h00 : job[base | 4'(k)];
    end

    // KW with more than 4 lanes spills into result bytes 4+, which KW never publishes
    always_comb begin
        res_nxt = res;
        for (int k = 0; k < NUM_SBOX; k++)
            res_nxt[base | 4'(k)] = lane_out[k];
    end

    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
        sbox u_sbox (.a(lane_in[i]), .y(lane_out[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            chunk   <= '0;
            prio    <= REQ_ST;
            job     <= '0;
            res     <= '0;
            st_done <= 1'b0;
            kw_done <= 1'b0;
            st_out  <= '0;
            kw_out  <= '0;
        end else begin
            state   <= state_nxt;
            chunk   <= (state == IDLE || last) ? 4'd0 : chunk + 4'd1;
            prio    <= st_gnt ? REQ_KW : kw_gnt ? REQ_ST : prio;
            job     <= st_gnt ? st_in : kw_gnt ? {kw_in, 96'h0} : job;
            res     <= (state == IDLE) ? res : res_nxt;
            st_done <= (state == ST_RUN) && last;
            kw_done <= (state == KW_RUN) && last;
            st_out  <= (state == ST_RUN && last) ? res_nxt : st_out;
            kw_out  <= (state == KW_RUN && last) ? res_nxt[0:3] : kw_out;
        end
    end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// tb_sbox_share_ctrl: table-driven model check of the sbox sequencer plus directed scenarios and a lane-count sweep
module tb_sbox_share_ctrl;
    localparam int NS = 4;
    localparam logic [31:0]  V1  = 32'h00010203;
    localparam logic [31:0]  V1R = 32'h637C777B;
    localparam logic [127:0] V2  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] V2R = 128'h638293C31BFC33F5C4EEACEA4BC12816;

    logic [0:255][7:0] sbt = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st_req, st_gnt, st_done, kw_req, kw_gnt, kw_done, busy;
    logic [127:0] st_in, st_out;
    logic [31:0] kw_in, kw_out;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sw_cnt = 0;
    int st_gnt_cyc, kw_gnt_cyc, st_done_cyc, kw_done_cyc, st_done_cnt;
    logic [7:0] ord [$];

    int m_cnt = 0;
    logic m_is_st = 1'b0;
    logic m_prio_kw = 1'b0;
    logic [127:0] m_res = '0;
    logic [127:0] m_st_out = '0;
    logic [31:0] m_kw_out = '0;
    logic m_st_done = 1'b0;
    logic m_kw_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_share_ctrl #(.NUM_SBOX(NS)) dut (
        .clk(clk), .rst(rst),
        .st_req(st_req), .st_in(st_in), .st_gnt(st_gnt), .st_done(st_done), .st_out(st_out),
        .kw_req(kw_req), .kw_in(kw_in), .kw_gnt(kw_gnt), .kw_done(kw_done), .kw_out(kw_out),
        .busy(busy));

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    function automatic logic [127:0] subbytes(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbt[x[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sbt[x[31-8*i -: 8]];
        return r;
    endfunction

    function automatic logic exp_st();
        return m_cnt == 0 && st_req && (!kw_req || !m_prio_kw);
    endfunction

    function automatic logic exp_kw();
        return m_cnt == 0 && kw_req && (!st_req || m_prio_kw);
    endfunction

    function automatic logic [31:0] ordn(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[23:0], (i < ord.size()) ? ord[i] : 8'h2e};
        return r;
    endfunction

    // model: a granted job finishes N cycles after its grant edge, done shows the cycle after
    task automatic model_step();
        if (rst) begin
            m_cnt = 0; m_prio_kw = 1'b0; m_st_out = '0; m_kw_out = '0;
            m_st_done = 1'b0; m_kw_done = 1'b0;
        end else begin
            m_st_done = 1'b0;
            m_kw_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0 && m_is_st) begin m_st_out = m_res; m_st_done = 1'b1; end
                if (m_cnt == 0 && !m_is_st) begin m_kw_out = m_res[31:0]; m_kw_done = 1'b1; end
            end else if (exp_st()) begin
                m_is_st = 1'b1; m_cnt = 16 / NS; m_res = subbytes(st_in); m_prio_kw = 1'b1;
            end else if (exp_kw()) begin
                m_is_st = 1'b0; m_cnt = (4 + NS - 1) / NS; m_res = {96'h0, subword(kw_in)}; m_prio_kw = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("st_gnt", st_gnt, exp_st());
        chk("kw_gnt", kw_gnt, exp_kw());
        chk("busy", busy, m_cnt != 0);
        chk("st_done", st_done, m_st_done);
        chk("kw_done", kw_done, m_kw_done);
        chk("st_out", st_out, m_st_out);
        chk("kw_out", kw_out, m_kw_out);
        if (st_gnt) begin st_gnt_cyc = cyc; ord.push_back("S"); end
        if (kw_gnt) begin kw_gnt_cyc = cyc; ord.push_back("K"); end
        if (st_done) begin st_done_cyc = cyc; st_done_cnt++; end
        if (kw_done) kw_done_cyc = cyc;
    end

    task automatic serve(input int n);
        logic sg, kg;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sg = st_gnt;
            kg = kw_gnt;
            @(posedge clk);
            #1;
            if (sg) st_req = 1'b0;
            if (kg) kw_req = 1'b0;
        end
    endtask

    initial begin
        int t, n;
        st_req = 1'b0; kw_req = 1'b0; st_in = '0; kw_in = '0; st_done_cnt = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_st_out", st_out, 0);
        chk("rst_kw_out", kw_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        kw_in = V1; kw_req = 1'b1;
        serve(6);
        chk("t1_kw_lat", kw_done_cyc - kw_gnt_cyc, 2);
        chk("t1_kw_out", kw_out, V1R);
        st_in = V2; st_req = 1'b1;
        serve(10);
        chk("t2_st_lat", st_done_cyc - st_gnt_cyc, 5);
        chk("t2_st_out", st_out, V2R);
        chk("t2_kw_kept", kw_out, V1R);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ord.delete();
        st_req = 1'b1; kw_req = 1'b1;
        serve(12);
        chk("t3_order", ordn(2), "SK");
        chk("t3_kw_gnt_at_st_done", kw_gnt_cyc, st_gnt_cyc + 5);
        ord.delete();
        st_req = 1'b1; kw_req = 1'b1;
        repeat (24) @(posedge clk);
        #1 st_req = 1'b0; kw_req = 1'b0;
        serve(8);
        chk("t3_rr_order", ordn(4), "SKSK");
        ord.delete();
        st_in = V2; st_req = 1'b1;
        serve(2);
        kw_in = 32'h53535353; kw_req = 1'b1;
        serve(12);
        chk("t4_order", ordn(2), "SK");
        chk("t4_kw_wait", kw_gnt_cyc, st_gnt_cyc + 5);
        chk("t4_st_out", st_out, V2R);
        chk("t4_kw_out", kw_out, 32'hEDEDEDED);
        st_in = V2; st_req = 1'b1;
        serve(3);
        n = st_done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_st_out", st_out, 0);
        chk("t5_kw_out", kw_out, 0);
        chk("t5_st_done", st_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        serve(8);
        chk("t5_no_done", st_done_cnt, n);
        kw_in = 32'h53535353; kw_req = 1'b1;
        serve(6);
        chk("t5_kw_out", kw_out, 32'hEDEDEDED);
        chk("t5_st_out_zero", st_out, 0);
        t = 0;
        while (sw_cnt < 4 && t < 200) begin @(posedge clk); t++; end
        chk("sweep_finished", sw_cnt, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int SN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        logic r, sr, kr, sg, kg, sd, kd, bz;
        logic [127:0] si, so;
        logic [31:0] ki, ko;

        sbox_share_ctrl #(.NUM_SBOX(SN)) u_sw (
            .clk(clk), .rst(r),
            .st_req(sr), .st_in(si), .st_gnt(sg), .st_done(sd), .st_out(so),
            .kw_req(kr), .kw_in(ki), .kw_gnt(kg), .kw_done(kd), .kw_out(ko),
            .busy(bz));

        initial begin
            int t;
            r = 1'b0; sr = 1'b0; kr = 1'b0; si = '0; ki = '0;
            #1 r = 1'b1;
            repeat (2) @(posedge clk);
            #1 r = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (j == 0) begin ki = V1; kr = 1'b1; end
                else begin si = V2; sr = 1'b1; end
                t = 0;
                @(negedge clk);
                while (!(sg || kg) && t < 40) begin @(negedge clk); t++; end
                chk($sformatf("sw%0d_gnt", SN), sg || kg, 1);
                @(posedge clk);
                #1 sr = 1'b0; kr = 1'b0;
                t = 1;
                @(negedge clk);
                while (!(sd || kd) && t < 40) begin @(negedge clk); t++; end
                chk($sformatf("sw%0d_lat%0d", SN, j), t, (j == 0) ? (4 + SN - 1) / SN + 1 : 16 / SN + 1);
                chk($sformatf("sw%0d_out%0d", SN, j), (j == 0) ? {96'h0, ko} : so, (j == 0) ? {96'h0, V1R} : V2R);
            end
            sw_cnt++;
        end
    end
endmodule
